hit_rate_monitor_multi: RTL and testbench

//  Parametrised successor to the single-counter hit statistic path. Counts hits from N_TDS x N_CH

---
 rtl/hit_rate_monitor_multi_pkg.sv | 21 ++
 rtl/hit_rate_monitor_multi_if.sv | 33 +++
 rtl/hit_rate_monitor_multi_window_timer.sv | 38 +++
 rtl/hit_rate_monitor_multi.sv | 194 +++++++++++++++++++
 tb/tb_hit_rate_monitor_multi.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/hit_rate_monitor_multi_pkg.sv
// rtl/hit_rate_monitor_multi_pkg.sv - shared encodings and defaults for the hit-rate monitor
package hit_stat_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int FLUSH_CYCLES = 2;

    localparam int N_TDS_DEF = 4;
    localparam int N_CH_DEF  = 104;
    localparam int CNT_W_DEF = 20;
    localparam int WIN_W_DEF = 20;

    // Shortest window whose timer can keep sampling through FLUSH and DONE without expiring there.
    localparam int GAPLESS_MIN_WIN = FLUSH_CYCLES + 2;

endpackage

// File: rtl/hit_rate_monitor_multi_if.sv
// rtl/hit_rate_monitor_multi_if.sv - control, hit and result bundle of the hit-rate monitor
interface hit_rate_monitor_multi_if #(
    parameter int N_TDS = hit_stat_pkg::N_TDS_DEF,
    parameter int N_CH  = hit_stat_pkg::N_CH_DEF,
    parameter int CNT_W = hit_stat_pkg::CNT_W_DEF,
    parameter int WIN_W = hit_stat_pkg::WIN_W_DEF
);
    logic                   start;
    logic                   continuous;
    logic [WIN_W-1:0]       windows;
    logic [N_TDS-1:0]       tds_select;
    logic [N_CH-1:0]        channel_select;
    logic [N_TDS*N_CH-1:0]  hit_vec;

    logic                   busy;
    logic                   ready;
    logic [CNT_W-1:0]       count_or;
    logic [N_TDS*CNT_W-1:0] count_tds;
    logic [N_TDS:0]         overflow;
    logic                   win_err;
    logic [7:0]             win_index;

    modport master (
        output start, continuous, windows, tds_select, channel_select, hit_vec,
        input  busy, ready, count_or, count_tds, overflow, win_err, win_index
    );

    modport slave (
        input  start, continuous, windows, tds_select, channel_select, hit_vec,
        output busy, ready, count_or, count_tds, overflow, win_err, win_index
    );

endinterface

// File: rtl/hit_rate_monitor_multi_window_timer.sv
// rtl/hit_rate_monitor_multi_window_timer.sv - loadable window down-counter, expires on its last sample cycle
module window_timer
    import hit_stat_pkg::*;
#(
    parameter int WIN_W = WIN_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIN_W-1:0] i_load_value,
    output logic             o_expire,
    output logic             o_running
);

    logic [WIN_W-1:0] r_cnt;
    logic             r_running;

    // A load on the expiry cycle restarts the timer seamlessly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_running <= 1'b0;
        end else if (i_load) begin
            r_cnt     <= i_load_value;
            r_running <= 1'b1;
        end else if (r_running) begin
            if (r_cnt == '0) begin
                r_running <= 1'b0;
            end else begin
                r_cnt <= r_cnt - WIN_W'(1);
            end
        end
    end

    assign o_expire  = r_running && (r_cnt == '0);
    assign o_running = r_running;

endmodule

// File: rtl/hit_rate_monitor_multi.sv
// rtl/hit_rate_monitor_multi.sv - windowed hit-cycle counters: one OR counter plus one per TDS
module hit_rate_monitor_multi
    import hit_stat_pkg::*;
#(
    parameter int N_TDS = N_TDS_DEF,
    parameter int N_CH  = N_CH_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int WIN_W = WIN_W_DEF
) (
    input  logic                    clk,
    input  logic                    resetn,
    hit_rate_monitor_multi_if.slave bus
);

    localparam int N_CNT = N_TDS + 1;

    state_t           r_state;
    logic             r_start_q;
    logic             r_ready;
    logic             r_win_err;
    logic             r_rearm;
    logic [7:0]       r_win_index;
    logic [1:0]       r_flush_cnt;

    logic             w_start_rise;
    logic             w_win_zero;
    logic             w_gapless;
    logic             w_arm;
    logic             w_done;
    logic             w_load;
    logic             w_expire;
    logic             w_running;
    logic [WIN_W-1:0] w_load_value;

    assign w_start_rise = bus.start & ~r_start_q;
    assign w_win_zero   = (bus.windows == '0);
    assign w_gapless    = bus.continuous && (bus.windows >= WIN_W'(GAPLESS_MIN_WIN));
    assign w_arm        = (r_state == ST_IDLE) && w_start_rise && !w_win_zero;
    assign w_done       = (r_state == ST_DONE);
    assign w_load_value = bus.windows - WIN_W'(1);

    // Long continuous windows reload at expiry so the next window samples during FLUSH/DONE;
    // short ones fall back to reloading from DONE.
    assign w_load = w_arm
                 || ((r_state == ST_COUNT) && w_expire && w_gapless)
                 || (w_done && !r_rearm && bus.continuous && !w_win_zero);

    window_timer #(.WIN_W(WIN_W)) u_timer (
        .clk          (clk),
        .rst_n        (resetn),
        .i_load       (w_load),
        .i_load_value (w_load_value),
        .o_expire     (w_expire),
        .o_running    (w_running)
    );

    logic [N_TDS*N_CH-1:0] w_s1_next;
    logic [N_TDS*N_CH-1:0] r_s1_hits;
    logic [N_TDS-1:0]      w_tds_any;
    logic [N_TDS-1:0]      r_s2_tds;
    logic                  r_s2_or;
    logic                  r_s1_tag;
    logic                  r_s2_tag;
    logic [N_CNT-1:0]      w_cnt_hit;

    always_comb begin
        w_s1_next = '0;
        w_tds_any = '0;
        for (int t = 0; t < N_TDS; t++) begin
            w_s1_next[t*N_CH +: N_CH] = bus.hit_vec[t*N_CH +: N_CH] & bus.channel_select
                                      & {N_CH{bus.tds_select[t]}};
            w_tds_any[t] = |r_s1_hits[t*N_CH +: N_CH];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_s1_hits <= '0;
            r_s1_tag  <= 1'b0;
            r_s2_tds  <= '0;
            r_s2_or   <= 1'b0;
            r_s2_tag  <= 1'b0;
        end else begin
            r_s1_hits <= w_s1_next;
            r_s1_tag  <= w_running;
            r_s2_tds  <= w_tds_any;
            r_s2_or   <= |w_tds_any;
            r_s2_tag  <= r_s1_tag;
        end
    end

    assign w_cnt_hit = {r_s2_or, r_s2_tds} & {N_CNT{r_s2_tag}};

    // Index N_TDS is the OR counter; the rest are per TDS.
    for (genvar g = 0; g < N_CNT; g++) begin : g_cnt
        logic [CNT_W-1:0] r_work;
        logic [CNT_W-1:0] r_pub;
        logic             r_ovf_work;
        logic             r_ovf_pub;

        // At DONE the stage-2 sample already belongs to the next window when sampling is gapless.
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                r_work     <= '0;
                r_pub      <= '0;
                r_ovf_work <= 1'b0;
                r_ovf_pub  <= 1'b0;
            end else begin
                if (w_arm) begin
                    r_work     <= '0;
                    r_ovf_work <= 1'b0;
                end else if (w_done) begin
                    r_work     <= CNT_W'(w_cnt_hit[g]);
                    r_ovf_work <= 1'b0;
                end else if (w_cnt_hit[g]) begin
                    if (&r_work) begin
                        r_ovf_work <= 1'b1;
                    end else begin
                        r_work <= r_work + CNT_W'(1);
                    end
                end
                if (w_done) begin
                    r_pub     <= r_work;
                    r_ovf_pub <= r_ovf_work;
                end
            end
        end

        assign bus.overflow[g] = r_ovf_pub;
        if (g < N_TDS) begin : g_tds
            assign bus.count_tds[g*CNT_W +: CNT_W] = r_pub;
        end else begin : g_or
            assign bus.count_or = r_pub;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_start_q   <= 1'b0;
            r_ready     <= 1'b0;
            r_win_err   <= 1'b0;
            r_rearm     <= 1'b0;
            r_win_index <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_start_q <= bus.start;
            case (r_state)
                ST_IDLE: begin
                    if (w_start_rise) begin
                        if (w_win_zero) begin
                            r_win_err <= 1'b1;
                        end else begin
                            r_win_err <= 1'b0;
                            r_ready   <= 1'b0;
                            r_state   <= ST_COUNT;
                        end
                    end
                end
                ST_COUNT: begin
                    if (w_expire) begin
                        r_flush_cnt <= '0;
                        r_rearm     <= w_gapless;
                        r_state     <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (r_flush_cnt == 2'(FLUSH_CYCLES - 1)) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_flush_cnt <= r_flush_cnt + 2'd1;
                    end
                end
                ST_DONE: begin
                    r_ready     <= 1'b1;
                    r_win_index <= r_win_index + 8'd1;
                    r_rearm     <= 1'b0;
                    if (r_rearm || (bus.continuous && !w_win_zero)) begin
                        r_state <= ST_COUNT;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.ready     = r_ready;
    assign bus.win_err   = r_win_err;
    assign bus.win_index = r_win_index;

endmodule

// File: tb/tb_hit_rate_monitor_multi.sv
// tb/tb_hit_rate_monitor_multi.sv - directed vector bench for hit_rate_monitor_multi
module tb_hit_rate_monitor_multi;

    localparam int NT = 4;
    localparam int NC = 104;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    hit_rate_monitor_multi_if #(.N_TDS(NT), .N_CH(NC), .CNT_W(20), .WIN_W(20)) bus ();
    hit_rate_monitor_multi_if #(.N_TDS(NT), .N_CH(NC), .CNT_W(4),  .WIN_W(20)) bus_s ();

    assign bus_s.start          = bus.start;
    assign bus_s.continuous     = bus.continuous;
    assign bus_s.windows        = bus.windows;
    assign bus_s.tds_select     = bus.tds_select;
    assign bus_s.channel_select = bus.channel_select;
    assign bus_s.hit_vec        = bus.hit_vec;

    hit_rate_monitor_multi #(.N_TDS(NT), .N_CH(NC), .CNT_W(20), .WIN_W(20)) u_dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    hit_rate_monitor_multi #(.N_TDS(NT), .N_CH(NC), .CNT_W(4), .WIN_W(20)) u_dut_small (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus_s.slave)
    );

    typedef struct {
        int              win;
        logic [3:0]      tds_sel;
        logic            mask5;
        logic [3:0]      hit_tds;
        int              hit_ch;
        int              exp_or;
        logic [3:0][19:0] exp_tds;
    } vec_t;

    vec_t vecs[7];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NT*NC-1:0] make_hits(input logic [3:0] tds, input int ch);
        logic [NT*NC-1:0] hv;
        hv = '0;
        for (int t = 0; t < NT; t++) begin
            if (tds[t]) hv[t*NC + ch] = 1'b1;
        end
        return hv;
    endfunction

    int exp_win[4];
    int sum_pub;
    int hits_driven;
    int ready_seen;
    logic [15:0] s_tds;
    logic [4:0]  s_ovf;
    int          e;

    initial begin
        vecs[0] = '{100, 4'hF, 1'b0, 4'b0001, 5,   100, {20'd0,  20'd0,  20'd0,  20'd100}};
        vecs[1] = '{50,  4'hF, 1'b1, 4'b1111, 5,   0,   {20'd0,  20'd0,  20'd0,  20'd0}};
        vecs[2] = '{50,  4'hF, 1'b0, 4'b1111, 5,   50,  {20'd50, 20'd50, 20'd50, 20'd50}};
        vecs[3] = '{20,  4'h5, 1'b0, 4'b1111, 5,   20,  {20'd0,  20'd20, 20'd0,  20'd20}};
        vecs[4] = '{1,   4'hF, 1'b0, 4'b1000, 0,   1,   {20'd1,  20'd0,  20'd0,  20'd0}};
        vecs[5] = '{30,  4'h0, 1'b0, 4'b1111, 103, 0,   {20'd0,  20'd0,  20'd0,  20'd0}};
        vecs[6] = '{7,   4'h2, 1'b0, 4'b0010, 103, 7,   {20'd0,  20'd0,  20'd7,  20'd0}};

        bus.start          = 1'b0;
        bus.continuous     = 1'b0;
        bus.windows        = '0;
        bus.tds_select     = '1;
        bus.channel_select = '1;
        bus.hit_vec        = '0;

        #12;
        chk("rst_busy",      128'(bus.busy),      128'd0);
        chk("rst_ready",     128'(bus.ready),     128'd0);
        chk("rst_count_or",  128'(bus.count_or),  128'd0);
        chk("rst_count_tds", 128'(bus.count_tds), 128'd0);
        chk("rst_overflow",  128'(bus.overflow),  128'd0);
        chk("rst_win_err",   128'(bus.win_err),   128'd0);
        chk("rst_win_index", 128'(bus.win_index), 128'd0);
        @(negedge clk);
        resetn = 1'b1;
        step();

        // Continuous windows of 10, hit on TDS0 ch5 every third cycle from the first sample cycle.
        bus.windows    = 20'd10;
        bus.continuous = 1'b1;
        for (int n = 0; n < 4; n++) exp_win[n] = 0;
        sum_pub     = 0;
        hits_driven = 0;
        step();
        bus.start = 1'b1;
        for (int cyc = 1; cyc <= 46; cyc++) begin
            step();
            bus.start = 1'b0;
            if (cyc == 35) bus.continuous = 1'b0;
            if ((cyc - 1) % 3 == 0) begin
                bus.hit_vec = make_hits(4'b0001, 5);
                if (cyc <= 40) begin
                    exp_win[(cyc - 1) / 10]++;
                    hits_driven++;
                end
            end else begin
                bus.hit_vec = '0;
            end
            if (cyc >= 13 && (cyc - 13) % 10 == 0 && cyc <= 43) begin
                chk("cont_index_before", 128'(bus.win_index), 128'((cyc - 13) / 10));
                chk("cont_busy_done",    128'(bus.busy),      128'd1);
                chk("cont_ready_before", 128'(bus.ready),     128'(cyc > 13));
            end
            if (cyc >= 14 && (cyc - 14) % 10 == 0 && cyc <= 44) begin
                chk("cont_count_or",    128'(bus.count_or),           128'(exp_win[(cyc - 14) / 10]));
                chk("cont_count_tds0",  128'(bus.count_tds[19:0]),    128'(exp_win[(cyc - 14) / 10]));
                chk("cont_count_tds1",  128'(bus.count_tds[79:20]),   128'd0);
                chk("cont_index_after", 128'(bus.win_index),          128'((cyc - 14) / 10 + 1));
                chk("cont_ready",       128'(bus.ready),              128'd1);
                chk("cont_busy_after",  128'(bus.busy),               128'(cyc < 44));
                sum_pub += int'(bus.count_or);
            end
        end
        chk("cont_sum_total", 128'(sum_pub), 128'(hits_driven));
        chk("cont_idle_end",  128'(bus.busy), 128'd0);
        bus.hit_vec = '0;

        for (int i = 0; i < 7; i++) begin
            bus.windows        = 20'(vecs[i].win);
            bus.tds_select     = vecs[i].tds_sel;
            bus.channel_select = '1;
            if (vecs[i].mask5) bus.channel_select[5] = 1'b0;
            bus.hit_vec        = make_hits(vecs[i].hit_tds, vecs[i].hit_ch);
            bus.continuous     = 1'b0;
            step();
            bus.start = 1'b1;
            step();
            bus.start = 1'b0;
            repeat (vecs[i].win + 2) step();
            chk($sformatf("v%0d_ready_pre", i), 128'(bus.ready), 128'd0);
            chk($sformatf("v%0d_busy_pre", i),  128'(bus.busy),  128'd1);
            step();
            chk($sformatf("v%0d_ready", i),     128'(bus.ready),     128'd1);
            chk($sformatf("v%0d_busy", i),      128'(bus.busy),      128'd0);
            chk($sformatf("v%0d_count_or", i),  128'(bus.count_or),  128'(vecs[i].exp_or));
            chk($sformatf("v%0d_count_tds", i), 128'(bus.count_tds), 128'(vecs[i].exp_tds));
            chk($sformatf("v%0d_overflow", i),  128'(bus.overflow),  128'd0);
            s_ovf[4] = (vecs[i].exp_or > 15);
            for (int t = 0; t < NT; t++) begin
                e = int'(vecs[i].exp_tds[t]);
                s_tds[t*4 +: 4] = (e > 15) ? 4'd15 : 4'(e);
                s_ovf[t] = (e > 15);
            end
            chk($sformatf("v%0d_small_or", i),  128'(bus_s.count_or),
                128'((vecs[i].exp_or > 15) ? 15 : vecs[i].exp_or));
            chk($sformatf("v%0d_small_tds", i), 128'(bus_s.count_tds), 128'(s_tds));
            chk($sformatf("v%0d_small_ovf", i), 128'(bus_s.overflow),  128'(s_ovf));
        end

        // windows==0 arm attempt, then a valid arm of 5.
        bus.windows        = '0;
        bus.tds_select     = '1;
        bus.channel_select = '1;
        bus.hit_vec        = make_hits(4'b0001, 5);
        step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("werr_set",  128'(bus.win_err), 128'd1);
        chk("werr_busy", 128'(bus.busy),    128'd0);
        bus.windows = 20'd5;
        step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("werr_clear", 128'(bus.win_err), 128'd0);
        chk("werr_armed", 128'(bus.busy),    128'd1);
        repeat (8) step();
        chk("werr_ready",    128'(bus.ready),    128'd1);
        chk("werr_count_or", 128'(bus.count_or), 128'd5);

        // Reset pulse at cycle 30 of a 100-cycle window.
        bus.windows = 20'd100;
        step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (29) step();
        chk("mid_busy_pre", 128'(bus.busy), 128'd1);
        resetn = 1'b0;
        #1;
        chk("mid_busy",      128'(bus.busy),      128'd0);
        chk("mid_ready",     128'(bus.ready),     128'd0);
        chk("mid_count_or",  128'(bus.count_or),  128'd0);
        chk("mid_count_tds", 128'(bus.count_tds), 128'd0);
        chk("mid_overflow",  128'(bus.overflow),  128'd0);
        chk("mid_win_index", 128'(bus.win_index), 128'd0);
        #2;
        resetn = 1'b1;
        ready_seen = 0;
        for (int c = 0; c < 110; c++) begin
            step();
            if (bus.ready || bus.busy) ready_seen++;
        end
        chk("mid_no_result_after", 128'(ready_seen), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
